// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - raw button inputs and conditioned outputs
interface button_conditioner_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] bi;
  logic [N_BTN-1:0] Level;
  logic [N_BTN-1:0] Press;
  logic [N_BTN-1:0] Release;
  logic [N_BTN-1:0] Rep;

  modport master (output bi, input Level, Press, Release, Rep);
  modport slave  (input bi, output Level, Press, Release, Rep);
endinterface

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-channel sync, debounce, edge pulses, auto-repeat
module button_conditioner #(
  parameter int N_BTN           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_DELAY    = 5000,
  parameter int REPEAT_RATE     = 1000
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  button_conditioner_if.slave   btn
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_RPT} rpt_state_t;

  logic [N_BTN-1:0] level_v, press_v, release_v, rep_v;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [DW-1:0]          dcnt_q, dcnt_d;
    logic                   level_q, level_d;
    logic                   press_q, release_q, rep_q, rep_d;
    logic                   rise, fall;
    rpt_state_t             state_q, state_d;
    logic [RW-1:0]          rcnt_q, rcnt_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
      dcnt_d  = dcnt_q;
      level_d = level_q;
      if (s == level_q) begin
        dcnt_d = '0;
      end else if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = s;
        dcnt_d  = '0;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end

    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    // Repeat decisions use the next Level so a release beats a coincident tick.
    always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      rep_d   = 1'b0;
      case (state_q)
        ST_IDLE: begin
          rep_d = rise;
          if (rise && REPEAT_EN) begin
            state_d = ST_DELAY;
            rcnt_d  = '0;
          end
        end
        ST_DELAY: begin
          if (!level_d) begin
            state_d = ST_IDLE;
            rcnt_d  = '0;
          end else if (rcnt_q == RW'(REPEAT_DELAY - 1)) begin
            rep_d   = 1'b1;
            rcnt_d  = '0;
            state_d = ST_RPT;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        ST_RPT: begin
          if (!level_d) begin
            state_d = ST_IDLE;
            rcnt_d  = '0;
          end else if (rcnt_q == RW'(REPEAT_RATE - 1)) begin
            rep_d  = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        sync_q    <= '0;
        dcnt_q    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        rep_q     <= 1'b0;
        state_q   <= ST_IDLE;
        rcnt_q    <= '0;
      end else begin
        sync_q    <= {sync_q[SYNC_STAGES-2:0], btn.bi[i]};
        dcnt_q    <= dcnt_d;
        level_q   <= level_d;
        press_q   <= rise;
        release_q <= fall;
        rep_q     <= rep_d;
        state_q   <= state_d;
        rcnt_q    <= rcnt_d;
      end
    end

    assign level_v[i]   = level_q;
    assign press_v[i]   = press_q;
    assign release_v[i] = release_q;
    assign rep_v[i]     = rep_q;
  end

  assign btn.Level   = level_v;
  assign btn.Press   = press_v;
  assign btn.Release = release_v;
  assign btn.Rep     = rep_v;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed table-driven bench for button_conditioner
module tb_button_conditioner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  button_conditioner_if #(.N_BTN(2)) ifa ();
  button_conditioner_if #(.N_BTN(2)) ifb ();

  button_conditioner #(
    .N_BTN(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .REPEAT_EN(1'b1), .REPEAT_DELAY(8), .REPEAT_RATE(3)
  ) dut_a (
    .Clk(clk), .Rst_n(rst_n), .btn(ifa.slave)
  );

  button_conditioner #(
    .N_BTN(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .REPEAT_EN(1'b0), .REPEAT_DELAY(8), .REPEAT_RATE(3)
  ) dut_b (
    .Clk(clk), .Rst_n(rst_n), .btn(ifb.slave)
  );

  typedef struct {
    logic [1:0] bi;
    int         n;
    logic [7:0] exp;   // {Level, Press, Release, Rep}
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [1:0] bi, input int n,
                              input logic [1:0] lvl, input logic [1:0] prs,
                              input logic [1:0] rel, input logic [1:0] rep);
    vec_t v;
    v.bi  = bi;
    v.n   = n;
    v.exp = {lvl, prs, rel, rep};
    tbl.push_back(v);
  endfunction

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  function automatic logic [7:0] outs_a();
    return {ifa.Level, ifa.Press, ifa.Release, ifa.Rep};
  endfunction

  function automatic logic [7:0] outs_b();
    return {ifb.Level, ifb.Press, ifb.Release, ifb.Rep};
  endfunction

  initial begin
    int pulses;
    int pulse_cyc;

    // held repeat, release colliding with a repeat tick at T+20
    add(2'b01, 5, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01, 1, 2'b01, 2'b01, 2'b00, 2'b01);
    add(2'b01, 7, 2'b01, 2'b00, 2'b00, 2'b00);
    add(2'b01, 1, 2'b01, 2'b00, 2'b00, 2'b01);
    add(2'b01, 2, 2'b01, 2'b00, 2'b00, 2'b00);
    add(2'b01, 1, 2'b01, 2'b00, 2'b00, 2'b01);
    add(2'b01, 2, 2'b01, 2'b00, 2'b00, 2'b00);
    add(2'b01, 1, 2'b01, 2'b00, 2'b00, 2'b01);
    add(2'b00, 2, 2'b01, 2'b00, 2'b00, 2'b00);
    add(2'b00, 1, 2'b01, 2'b00, 2'b00, 2'b01);
    add(2'b00, 2, 2'b01, 2'b00, 2'b00, 2'b00);
    add(2'b00, 1, 2'b00, 2'b00, 2'b01, 2'b00);
    add(2'b00, 3, 2'b00, 2'b00, 2'b00, 2'b00);
    // per-cycle bounce is rejected
    for (int k = 0; k < 7; k++) add((k % 2 == 0) ? 2'b01 : 2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b00, 8, 2'b00, 2'b00, 2'b00, 2'b00);
    // 3-cycle pulse is one short of acceptance
    add(2'b01, 3, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b00, 8, 2'b00, 2'b00, 2'b00, 2'b00);
    // 4-cycle pulse is accepted, then released before the first repeat
    add(2'b01, 4, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b00, 1, 2'b01, 2'b01, 2'b00, 2'b01);
    add(2'b00, 3, 2'b01, 2'b00, 2'b00, 2'b00);
    add(2'b00, 1, 2'b00, 2'b00, 2'b01, 2'b00);
    add(2'b00, 4, 2'b00, 2'b00, 2'b00, 2'b00);
    // two channels, channel 1 pressed two cycles later
    add(2'b01, 2, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b11, 3, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b11, 1, 2'b01, 2'b01, 2'b00, 2'b01);
    add(2'b11, 1, 2'b01, 2'b00, 2'b00, 2'b00);
    add(2'b11, 1, 2'b11, 2'b10, 2'b00, 2'b10);
    add(2'b11, 5, 2'b11, 2'b00, 2'b00, 2'b00);
    add(2'b11, 1, 2'b11, 2'b00, 2'b00, 2'b01);
    add(2'b11, 1, 2'b11, 2'b00, 2'b00, 2'b00);
    add(2'b11, 1, 2'b11, 2'b00, 2'b00, 2'b10);
    add(2'b11, 1, 2'b11, 2'b00, 2'b00, 2'b01);
    add(2'b11, 1, 2'b11, 2'b00, 2'b00, 2'b00);
    add(2'b11, 1, 2'b11, 2'b00, 2'b00, 2'b10);
    add(2'b11, 1, 2'b11, 2'b00, 2'b00, 2'b01);
    add(2'b00, 1, 2'b11, 2'b00, 2'b00, 2'b00);
    add(2'b00, 1, 2'b11, 2'b00, 2'b00, 2'b10);
    add(2'b00, 1, 2'b11, 2'b00, 2'b00, 2'b01);
    add(2'b00, 1, 2'b11, 2'b00, 2'b00, 2'b00);
    add(2'b00, 1, 2'b11, 2'b00, 2'b00, 2'b10);
    add(2'b00, 1, 2'b00, 2'b00, 2'b11, 2'b00);
    add(2'b00, 4, 2'b00, 2'b00, 2'b00, 2'b00);

    ifa.bi = 2'b00;
    ifb.bi = 2'b00;
    #1;
    check8("reset_a", outs_a(), 8'h00);
    check8("reset_b", outs_b(), 8'h00);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    foreach (tbl[r]) begin
      for (int c = 0; c < tbl[r].n; c++) begin
        ifa.bi = tbl[r].bi;
        @(posedge clk);
        #1;
        check8($sformatf("row%0d_cyc%0d", r, c), outs_a(), tbl[r].exp);
        checks++;
        if ((ifa.Press & ifa.Release) != 2'b00) begin
          errors++;
          $display("FAIL press_and_release row%0d: got %b/%b required disjoint", r, ifa.Press, ifa.Release);
        end
      end
    end

    // REPEAT_EN=0: one Rep pulse, identical to Press, at the 6th edge
    pulses = 0;
    pulse_cyc = -1;
    ifb.bi = 2'b10;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      check8($sformatf("norpt_rep_eq_press_%0d", c), {6'b0, ifb.Rep}, {6'b0, ifb.Press});
      if (ifb.Rep != 2'b00) begin
        pulses++;
        pulse_cyc = c;
      end
    end
    check_int("norpt_pulse_count", pulses, 1);
    check_int("norpt_pulse_cycle", pulse_cyc, 6);
    check8("norpt_level_held", outs_b(), 8'b10_00_00_00);
    ifb.bi = 2'b00;

    // async reset while channel 0 is in auto-repeat, button kept held
    ifa.bi = 2'b01;
    repeat (20) @(posedge clk);
    #1;
    check8("pre_reset_level", {6'b0, ifa.Level}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check8("async_reset_outputs", outs_a(), 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check8("reset_held_outputs", outs_a(), 8'h00);
    #2 rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      check8($sformatf("post_reset_quiet_%0d", c), outs_a(), 8'h00);
    end
    @(posedge clk);
    #1;
    check8("post_reset_press", outs_a(), 8'b01_01_00_01);
    ifa.bi = 2'b00;
    repeat (10) @(posedge clk);
    #1;
    check8("final_idle_a", outs_a(), 8'h00);
    check8("final_idle_b", outs_b(), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
